// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampled SPI slave.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
  localparam int C_SYNC_STAGES = 2;
endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with rise/fall pulses; pulses appear STAGES cycles after the input moves.
// RST_VAL lets chip select reset "asserted" so a CS held low through reset is not seen as a new fall.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_slave.sv
// SPI slave oversampled on clk_sys, all four modes, one-deep tx holding register with ready/valid.
// Optional sticky partial-word detection is built only when SPI_SLAVE_FRAME_ERR_EN is defined.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                          G_SPI_SIZE       = 1,
  parameter int                          G_SPI_DATA_WIDTH = 8,
  parameter logic [G_SPI_DATA_WIDTH-1:0] G_IDLE_DATA      = '0
) (
  input  logic                        clk_sys,
  input  logic                        rst_n_sys,
  input  logic                        cpol,
  input  logic                        cpha,
  input  logic                        spi_clk,
  input  logic                        spi_cs_n,
  input  logic [G_SPI_SIZE-1:0]       spi_di,
  output logic [G_SPI_SIZE-1:0]       spi_do,
  input  logic [G_SPI_DATA_WIDTH-1:0] tx_data,
  input  logic                        tx_val,
  output logic                        tx_rdy,
  output logic [G_SPI_DATA_WIDTH-1:0] rx_data,
  output logic                        rx_val,
  output logic                        busy,
  output logic                        frame_err
);
  localparam int W  = G_SPI_DATA_WIDTH;
  localparam int S  = G_SPI_SIZE;
  localparam int CW = $clog2(W + 1);

  state_t state, state_nxt;
  logic clk_rise, clk_fall, cs_rise, cs_fall;
  logic [C_SYNC_STAGES-1:0][S-1:0] di_q;
  logic [S-1:0]  di_s;
  logic [W-1:0]  tx_sr, rx_sr, hold_data, next_word, rx_shift;
  logic          hold_full, fresh;
  logic [CW-1:0] bit_cnt, cnt_inc;
  logic sample_ev, shift_ev, ld_frame, smp, shf_ev, shf, rld, consume;

  spi_sync_edge #(.STAGES(C_SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
    .clk(clk_sys), .rst_n(rst_n_sys), .sig(spi_clk), .rise(clk_rise), .fall(clk_fall)
  );
  spi_sync_edge #(.STAGES(C_SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .clk(clk_sys), .rst_n(rst_n_sys), .sig(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) di_q <= '0;
    else            di_q <= {di_q[C_SYNC_STAGES-2:0], spi_di};
  end
  assign di_s = di_q[C_SYNC_STAGES-1];

  assign sample_ev = (cpol == cpha) ? clk_rise : clk_fall;
  assign shift_ev  = (cpol == cpha) ? clk_fall : clk_rise;

  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_frame  = 1'b0;
    smp       = 1'b0;
    shf_ev    = 1'b0;
    case (state)
      IDLE:   if (cs_fall) state_nxt = LOAD;
      LOAD: begin
        ld_frame  = 1'b1;
        state_nxt = cs_rise ? IDLE : ACTIVE;
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_nxt = IDLE;
        end else begin
          smp    = sample_ev;
          shf_ev = shift_ev;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A word boundary reloads on the shift edge, except the frame's first word which LOAD already placed.
  assign shf       = shf_ev && (bit_cnt != '0);
  assign rld       = shf_ev && (bit_cnt == '0) && !fresh;
  assign consume   = ld_frame | rld;
  assign next_word = hold_full ? hold_data : G_IDLE_DATA;
  assign cnt_inc   = bit_cnt + CW'(S);
  assign rx_shift  = (rx_sr << S) | W'(di_s);

  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data   <= '0;
      rx_val    <= 1'b0;
      bit_cnt   <= '0;
      fresh     <= 1'b0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      rx_val <= 1'b0;
      if (ld_frame) begin
        tx_sr   <= next_word;
        bit_cnt <= '0;
        fresh   <= 1'b1;
      end else if (rld) begin
        tx_sr <= next_word;
      end else if (shf) begin
        tx_sr <= tx_sr << S;
      end
      if (shf_ev) fresh <= 1'b0;
      if (smp) begin
        rx_sr <= rx_shift;
        if (cnt_inc == CW'(W)) begin
          rx_data <= rx_shift;
          rx_val  <= 1'b1;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= cnt_inc;
        end
      end
      // A new word accepted in the same cycle as a consume wins, keeping the register full.
      if (tx_val && tx_rdy) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (consume) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign tx_rdy = ~hold_full;
  assign busy   = (state != IDLE);
  assign spi_do = (state == IDLE) ? '0 : tx_sr[W-1 -: S];

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q;
  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys)                                    frame_err_q <= 1'b0;
    else if (ld_frame)                                 frame_err_q <= 1'b0;
    else if (state == ACTIVE && cs_rise && bit_cnt != '0) frame_err_q <= 1'b1;
  end
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench: bit-banged SPI master in all modes against an 8-bit/1-lane and an 8-bit/2-lane slave.
module tb_spi_slave;
  localparam int H = 6;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam logic FE_EXP = 1'b1;
`else
  localparam logic FE_EXP = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic rst_n_sys, cpol, cpha, spi_clk, spi_cs_n;
  logic       spi_di1, spi_do1;
  logic [1:0] spi_di2, spi_do2;
  logic [7:0] tx_data, rx_data, rx_data2;
  logic       tx_val, tx_rdy, rx_val, busy, frame_err;
  logic       tx_rdy2, rx_val2, busy2, frame_err2;
  logic [23:0] miso;
  int rx_cnt = 0;
  int rx_cnt2 = 0;
  int checks = 0;
  int passes = 0;
  int fails = 0;
  int c0;

  always #5 clk_sys = ~clk_sys;

  spi_slave #(.G_SPI_SIZE(1), .G_SPI_DATA_WIDTH(8), .G_IDLE_DATA(8'hE7)) dut (
    .clk_sys(clk_sys), .rst_n_sys(rst_n_sys), .cpol(cpol), .cpha(cpha),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_di(spi_di1), .spi_do(spi_do1),
    .tx_data(tx_data), .tx_val(tx_val), .tx_rdy(tx_rdy),
    .rx_data(rx_data), .rx_val(rx_val), .busy(busy), .frame_err(frame_err)
  );

  spi_slave #(.G_SPI_SIZE(2), .G_SPI_DATA_WIDTH(8)) dut2 (
    .clk_sys(clk_sys), .rst_n_sys(rst_n_sys), .cpol(cpol), .cpha(cpha),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_di(spi_di2), .spi_do(spi_do2),
    .tx_data(8'h00), .tx_val(1'b0), .tx_rdy(tx_rdy2),
    .rx_data(rx_data2), .rx_val(rx_val2), .busy(busy2), .frame_err(frame_err2)
  );

  always @(posedge clk_sys) begin
    if (rx_val)  rx_cnt  <= rx_cnt + 1;
    if (rx_val2) rx_cnt2 <= rx_cnt2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  function automatic logic [1:0] grp(input logic [23:0] v, input int lanes, input int ngrp, input int i);
    logic [23:0] t;
    t = v >> ((ngrp - 1 - i) * lanes);
    return (lanes == 2) ? t[1:0] : {1'b0, t[0]};
  endfunction

  task automatic drive(input logic [1:0] g);
    spi_di2 = g;
    spi_di1 = g[0];
  endtask

  task automatic take(input int lanes, inout logic [23:0] acc);
    acc = (lanes == 2) ? ((acc << 2) | 24'(spi_do2)) : ((acc << 1) | 24'(spi_do1));
  endtask

  task automatic push(input logic [7:0] w);
    @(negedge clk_sys);
    tx_data = w;
    tx_val  = 1'b1;
    @(negedge clk_sys);
    tx_val  = 1'b0;
  endtask

  // One CS-framed burst of ngrp lane groups; master samples on its leading (cpha=0) or trailing (cpha=1) edge.
  task automatic frame(input logic cp, input logic ph, input int lanes, input int ngrp,
                       input logic [23:0] mosi, output logic [23:0] rx);
    rx = '0;
    @(negedge clk_sys);
    cpol = cp; cpha = ph; spi_clk = cp;
    idle_cycles(H);
    spi_cs_n = 1'b0;
    if (!ph) drive(grp(mosi, lanes, ngrp, 0));
    idle_cycles(8);
    for (int i = 0; i < ngrp; i++) begin
      spi_clk = ~cp;
      if (ph) drive(grp(mosi, lanes, ngrp, i));
      else    take(lanes, rx);
      idle_cycles(H);
      spi_clk = cp;
      if (ph)               take(lanes, rx);
      else if (i + 1 < ngrp) drive(grp(mosi, lanes, ngrp, i + 1));
      idle_cycles(H);
    end
    spi_cs_n = 1'b1;
    idle_cycles(12);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n_sys = 1'b0; cpol = 1'b0; cpha = 1'b0; spi_clk = 1'b0; spi_cs_n = 1'b1;
    spi_di1 = 1'b0; spi_di2 = 2'b00; tx_data = 8'h00; tx_val = 1'b0;
    idle_cycles(3);
    chk("rst_spi_do", 32'(spi_do1), 32'h0);
    chk("rst_tx_rdy", 32'(tx_rdy), 32'h1);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_val", 32'(rx_val), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n_sys = 1'b1;
    idle_cycles(4);

    for (int m = 0; m < 4; m++) begin
      push(8'hA5);
      c0 = rx_cnt;
      frame(m[1], m[0], 1, 8, 24'h00003C, miso);
      chk($sformatf("mode%0d_rx_data", m), 32'(rx_data), 32'h3C);
      chk($sformatf("mode%0d_rx_val_cnt", m), 32'(rx_cnt - c0), 32'd1);
      chk($sformatf("mode%0d_miso", m), 32'(miso), 32'hA5);
    end

    push(8'h11);
    chk("hold_full_tx_rdy", 32'(tx_rdy), 32'h0);
    c0 = rx_cnt;
    frame(1'b0, 1'b0, 1, 24, 24'h123456, miso);
    chk("3w_rx_val_cnt", 32'(rx_cnt - c0), 32'd3);
    chk("3w_rx_data", 32'(rx_data), 32'h56);
    chk("3w_miso", 32'(miso), 32'h11E7E7);
    chk("3w_tx_rdy", 32'(tx_rdy), 32'h1);

    c0 = rx_cnt;
    frame(1'b0, 1'b0, 1, 5, 24'h000015, miso);
    chk("partial_rx_val_cnt", 32'(rx_cnt - c0), 32'd0);
    chk("partial_rx_data", 32'(rx_data), 32'h56);
    chk("partial_frame_err", 32'(frame_err), 32'(FE_EXP));
    c0 = rx_cnt;
    frame(1'b0, 1'b0, 1, 8, 24'h000096, miso);
    chk("after_partial_rx_data", 32'(rx_data), 32'h96);
    chk("after_partial_rx_cnt", 32'(rx_cnt - c0), 32'd1);
    chk("after_partial_frame_err", 32'(frame_err), 32'h0);

    // Reset in the middle of a word, with a word waiting in the holding register.
    @(negedge clk_sys);
    cpol = 1'b0; cpha = 1'b0; spi_clk = 1'b0;
    idle_cycles(H);
    spi_cs_n = 1'b0; spi_di1 = 1'b1;
    idle_cycles(8);
    spi_clk = 1'b1; idle_cycles(H);
    spi_clk = 1'b0; idle_cycles(H);
    spi_clk = 1'b1; idle_cycles(H);
    push(8'h33);
    chk("midword_busy", 32'(busy), 32'h1);
    chk("midword_tx_rdy", 32'(tx_rdy), 32'h0);
    rst_n_sys = 1'b0;
    #1;
    chk("midrst_spi_do", 32'(spi_do1), 32'h0);
    chk("midrst_tx_rdy", 32'(tx_rdy), 32'h1);
    chk("midrst_rx_data", 32'(rx_data), 32'h0);
    chk("midrst_rx_val", 32'(rx_val), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_frame_err", 32'(frame_err), 32'h0);
    chk("midrst_busy2", 32'(busy2), 32'h0);
    chk("midrst_tx_rdy2", 32'(tx_rdy2), 32'h1);
    chk("midrst_frame_err2", 32'(frame_err2), 32'h0);
    spi_clk = 1'b0;
    idle_cycles(4);
    rst_n_sys = 1'b1;
    idle_cycles(4);
    spi_cs_n = 1'b1;
    idle_cycles(6);
    chk("post_rst_busy", 32'(busy), 32'h0);
    c0 = rx_cnt;
    frame(1'b0, 1'b0, 1, 8, 24'h00005A, miso);
    chk("post_rst_rx_data", 32'(rx_data), 32'h5A);
    chk("post_rst_rx_cnt", 32'(rx_cnt - c0), 32'd1);

    c0 = rx_cnt2;
    frame(1'b0, 1'b0, 2, 4, 24'h0000C3, miso);
    chk("lanes2_rx_data", 32'(rx_data2), 32'hC3);
    chk("lanes2_rx_cnt", 32'(rx_cnt2 - c0), 32'd1);
    chk("lanes2_miso", 32'(miso), 32'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
